// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the oversampling receiver.
package uart_pkg;

    // Default bit period (peripheral clocks per bit) and frame data width.
    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    // Transmit frame sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/counter.sv
// Generic modulo counter: counts 0..MODULUS-1 while enabled, wraps to 0,
// and is held at 0 by a synchronous clear (clear has priority over enable).
module counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    // Count register with clear, enable and wrap at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tx_holding_reg.sv
// One-entry valid/ready buffer between the host and the transmit shifter.
// Ready depends only on the full flag, never on the incoming valid.
module tx_holding_reg
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = UART_DATA_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_push;

    assign w_push = i_valid && !r_full;

    // Capture a byte when empty; the consumer pops only while full, so
    // push and pop are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (w_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, STOP_BITS stop
// bits, each held CLKS_PER_BIT clocks. A holding register allows the next
// byte to be queued so back-to-back frames have no idle gap.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic                 tx_bitstream,
    output logic                 active_tx,
    output logic                 done
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

    tx_state_t r_state;
    tx_state_t w_state_next;

    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_tx;
    logic                 w_tx_next;

    logic                 w_hold_full;
    logic [DATA_BITS-1:0] w_hold_data;
    logic                 w_pop;

    logic [TW-1:0] w_timer;
    logic [IW-1:0] w_bit_idx;
    logic          w_stop_cnt;

    logic w_bit_end;
    logic w_last_bit;
    logic w_last_stop;
    logic w_done;

    tx_holding_reg #(
        .WIDTH (DATA_BITS)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (data_in_valid),
        .i_data  (data_in),
        .o_ready (data_in_ready),
        .i_pop   (w_pop),
        .o_full  (w_hold_full),
        .o_data  (w_hold_data)
    );

    // Bit timer free-runs for the whole frame and is parked at 0 in IDLE.
    counter #(
        .WIDTH   (TW),
        .MODULUS (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state == IDLE),
        .i_en    (r_state != IDLE),
        .o_count (w_timer)
    );

    counter #(
        .WIDTH   (IW),
        .MODULUS (DATA_BITS)
    ) u_bit_index (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state != DATA),
        .i_en    ((r_state == DATA) && w_bit_end),
        .o_count (w_bit_idx)
    );

    counter #(
        .WIDTH   (1),
        .MODULUS (STOP_BITS)
    ) u_stop_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state != STOP),
        .i_en    ((r_state == STOP) && w_bit_end),
        .o_count (w_stop_cnt)
    );

    assign w_bit_end   = (r_state != IDLE) && (w_timer == TIMER_LAST);
    assign w_last_bit  = (w_bit_idx == INDEX_LAST);
    assign w_last_stop = (w_stop_cnt == STOP_LAST);

    // Next-state, shift-register and line-level decode.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hold_full) begin
                    w_state_next = START_BIT;
                    w_shift_next = w_hold_data;
                    w_pop        = 1'b1;
                end
            end
            START_BIT: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (w_last_bit) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_done = 1'b1;
                    if (w_hold_full) begin
                        w_state_next = START_BIT;
                        w_shift_next = w_hold_data;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // The line is registered, so it is derived from the next state.
        unique case (w_state_next)
            START_BIT: w_tx_next = 1'b0;
            DATA:      w_tx_next = w_shift_next[0];
            default:   w_tx_next = 1'b1;
        endcase
    end

    // State, shift register and registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    assign tx_bitstream = r_tx;
    assign active_tx    = (r_state != IDLE);
    assign done         = w_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed testbench for uart_transmitter: default instance plus a
// CLKS_PER_BIT=4 / DATA_BITS=7 / STOP_BITS=2 instance decoded by a bench receiver.
module tb_uart_transmitter;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       tx_bitstream;
    logic       active_tx;
    logic       done;

    logic [6:0] d2_in;
    logic       d2_valid;
    logic       d2_ready;
    logic       d2_tx;
    logic       d2_active;
    logic       d2_done;

    int errors;
    int checks;

    uart_transmitter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .tx_bitstream  (tx_bitstream),
        .active_tx     (active_tx),
        .done          (done)
    );

    uart_transmitter #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (7),
        .STOP_BITS    (2)
    ) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (d2_in),
        .data_in_valid (d2_valid),
        .data_in_ready (d2_ready),
        .tx_bitstream  (d2_tx),
        .active_tx     (d2_active),
        .done          (d2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        d2_in = '0;
        d2_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_bitstream !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_bitstream); end
        checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", data_in_ready); end
        checks++; if (active_tx !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active_tx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (d2_tx !== 1'b1) begin errors++; $display("FAIL reset_d2_tx: got %b expected 1", d2_tx); end
        rst_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            checks++; if (tx_bitstream !== 1'b1) begin errors++; $display("FAIL idle_tx cycle %0d: got %b expected 1", n, tx_bitstream); end
            checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready cycle %0d: got %b expected 1", n, data_in_ready); end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        int act_cnt;
        int done_cnt;
        int done_at;
        frame = 10'b1_1010_0101_0;
        act_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        @(negedge clk);
        data_in = 8'hA5;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        data_in = 8'hFF;
        @(negedge clk);
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_accept: got %b expected 0", data_in_ready); end
        checks++; if (tx_bitstream !== 1'b1) begin errors++; $display("FAIL single_tx_before_start: got %b expected 1", tx_bitstream); end
        for (int n = 1; n <= 170; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n <= 160) begin
                checks++;
                if (tx_bitstream !== frame[(n-1)/16]) begin
                    errors++;
                    $display("FAIL single_tx cycle %0d: got %b expected %b", n, tx_bitstream, frame[(n-1)/16]);
                end
            end
            if (active_tx === 1'b1) act_cnt++;
            if (done === 1'b1) begin done_cnt++; done_at = n; end
        end
        checks++; if (act_cnt != 160) begin errors++; $display("FAIL single_active_len: got %0d expected 160", act_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at != 160) begin errors++; $display("FAIL single_done_cycle: got %0d expected 160", done_at); end
        checks++; if (tx_bitstream !== 1'b1) begin errors++; $display("FAIL single_tx_idle_after: got %b expected 1", tx_bitstream); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] frames;
        int act_cnt;
        logic exp_done;
        frames = {10'b1_1111_1111_0, 10'b1_0000_0000_0};
        act_cnt = 0;
        @(negedge clk);
        data_in = 8'h00;
        data_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_in = 8'hFF;
        for (int n = 1; n <= 330; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n <= 320) begin
                checks++;
                if (tx_bitstream !== frames[(n-1)/16]) begin
                    errors++;
                    $display("FAIL b2b_tx cycle %0d: got %b expected %b", n, tx_bitstream, frames[(n-1)/16]);
                end
            end else begin
                checks++;
                if (tx_bitstream !== 1'b1) begin errors++; $display("FAIL b2b_tx_idle cycle %0d: got %b expected 1", n, tx_bitstream); end
            end
            exp_done = (n == 160) || (n == 320);
            checks++;
            if (done !== exp_done) begin errors++; $display("FAIL b2b_done cycle %0d: got %b expected %b", n, done, exp_done); end
            if (active_tx === 1'b1) act_cnt++;
            if (n == 1) begin
                checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_load: got %b expected 1", data_in_ready); end
            end
            if (n == 2) begin
                checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b expected 0", data_in_ready); end
                data_in_valid = 1'b0;
            end
            if (n == 160) begin
                checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b expected 0", data_in_ready); end
            end
            if (n == 161) begin
                checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_second_load: got %b expected 1", data_in_ready); end
            end
        end
        checks++; if (act_cnt != 320) begin errors++; $display("FAIL b2b_active_span: got %0d expected 320", act_cnt); end
    endtask

    task automatic test_host_stall();
        logic [7:0] bytes [3];
        logic [7:0] rx_bytes [3];
        logic [7:0] rx_sr;
        int accepted;
        int starts;
        int rx_n;
        int ferr;
        int cnt;
        int j;
        bit busy;
        bit will_accept;
        logic exp_ready;
        bytes = '{8'h3C, 8'h81, 8'h7E};
        rx_bytes = '{8'h00, 8'h00, 8'h00};
        rx_sr = '0;
        accepted = 0;
        starts = 0;
        rx_n = 0;
        ferr = 0;
        cnt = 0;
        busy = 1'b0;
        for (int n = 0; n < 560; n++) begin
            @(negedge clk);
            if (!busy && tx_bitstream === 1'b0) begin
                busy = 1'b1;
                cnt = 0;
                starts++;
            end else if (busy) begin
                cnt++;
            end
            if (busy && (cnt % 16) == 8) begin
                j = cnt / 16;
                if (j == 0 && tx_bitstream !== 1'b0) ferr++;
                if (j >= 1 && j <= 8) rx_sr[j-1] = tx_bitstream;
                if (j == 9) begin
                    if (tx_bitstream !== 1'b1) ferr++;
                    if (rx_n < 3) rx_bytes[rx_n] = rx_sr;
                    rx_n++;
                    busy = 1'b0;
                end
            end
            exp_ready = (accepted == starts);
            checks++;
            if (data_in_ready !== exp_ready) begin
                errors++;
                $display("FAIL stall_ready cycle %0d: got %b expected %b", n, data_in_ready, exp_ready);
            end
            if (accepted < 3) begin
                data_in_valid = 1'b1;
                data_in = bytes[accepted];
            end else begin
                data_in_valid = 1'b0;
            end
            will_accept = (data_in_valid === 1'b1) && (data_in_ready === 1'b1);
            @(posedge clk);
            if (will_accept) accepted++;
        end
        data_in_valid = 1'b0;
        checks++; if (rx_n != 3) begin errors++; $display("FAIL stall_frame_count: got %0d expected 3", rx_n); end
        checks++; if (ferr != 0) begin errors++; $display("FAIL stall_framing: got %0d errors expected 0", ferr); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx_bytes[k] !== bytes[k]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", k, rx_bytes[k], bytes[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int low_cnt;
        int act_cnt;
        int done_cnt;
        low_cnt = 0;
        act_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        data_in = 8'h33;
        data_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_in = 8'hC3;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 2) data_in_valid = 1'b0;
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (tx_bitstream !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: got %b expected 0", tx_bitstream); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_ready: got %b expected 0", data_in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_bitstream !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b expected 1", tx_bitstream); end
        checks++; if (active_tx !== 1'b0) begin errors++; $display("FAIL rst_async_active: got %b expected 0", active_tx); end
        checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", data_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (tx_bitstream !== 1'b1) low_cnt++;
            if (active_tx === 1'b1) act_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (low_cnt != 0) begin errors++; $display("FAIL rst_line_after: got %0d low cycles expected 0", low_cnt); end
        checks++; if (act_cnt != 0) begin errors++; $display("FAIL rst_queued_discard: got %0d active cycles expected 0", act_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", done_cnt); end
    endtask

    task automatic test_param_sweep();
        logic [9:0] frame;
        logic [6:0] rx;
        int act_cnt;
        int done_cnt;
        int done_at;
        int ferr;
        int j;
        frame = 10'b11_1010101_0;
        rx = '0;
        act_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        ferr = 0;
        @(negedge clk);
        d2_in = 7'h55;
        d2_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_valid = 1'b0;
        d2_in = 7'h2A;
        for (int n = 1; n <= 48; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n <= 40) begin
                checks++;
                if (d2_tx !== frame[(n-1)/4]) begin
                    errors++;
                    $display("FAIL sweep_tx cycle %0d: got %b expected %b", n, d2_tx, frame[(n-1)/4]);
                end
                if ((n % 4) == 3) begin
                    j = (n - 3) / 4;
                    if (j == 0 && d2_tx !== 1'b0) ferr++;
                    if (j >= 1 && j <= 7) rx[j-1] = d2_tx;
                    if (j >= 8 && d2_tx !== 1'b1) ferr++;
                end
            end
            if (d2_active === 1'b1) act_cnt++;
            if (d2_done === 1'b1) begin done_cnt++; done_at = n; end
        end
        checks++; if (act_cnt != 40) begin errors++; $display("FAIL sweep_frame_len: got %0d expected 40", act_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL sweep_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at != 40) begin errors++; $display("FAIL sweep_done_cycle: got %0d expected 40", done_at); end
        checks++; if (rx !== 7'h55) begin errors++; $display("FAIL sweep_loopback: got %h expected 55", rx); end
        checks++; if (ferr != 0) begin errors++; $display("FAIL sweep_framing: got %0d errors expected 0", ferr); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_host_stall();
        test_reset_mid_frame();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
